// File: rtl/bsg_array_expand_serial.sv
// Serial array expander: collects dense beats into a buffer, then scatters the
// buffer into a sparse array whose occupied positions are the set bits of pattern_p.
module bsg_array_expand_serial #(
    parameter int unsigned width_p       = 1,
    parameter int unsigned pattern_els_p = 512,
    parameter logic [pattern_els_p-1:0] pattern_p = {{256{1'b0}}, {256{1'b1}}},
    parameter int unsigned dense_els_p   = 256,
    parameter int unsigned beat_els_p    = 32
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               v_i,
    input  logic [width_p*beat_els_p-1:0]      data_i,
    output logic                               ready_o,
    output logic                               v_o,
    output logic [width_p*pattern_els_p-1:0]   data_o,
    input  logic                               yumi_i
);

    localparam int unsigned beats_lp   = dense_els_p / beat_els_p;
    localparam int unsigned cnt_w_lp   = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam int unsigned beat_w_lp  = width_p * beat_els_p;
    localparam int unsigned dense_w_lp = width_p * dense_els_p;

    function automatic int unsigned popcount_f(input logic [pattern_els_p-1:0] p);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < pattern_els_p; i++) begin
            if (p[i]) n++;
        end
        return n;
    endfunction

    // Dense index feeding sparse position j: number of set pattern bits below j.
    function automatic int unsigned rank_f(input int unsigned j);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < j; i++) begin
            if (pattern_p[i]) n++;
        end
        return n;
    endfunction

    if (popcount_f(pattern_p) != dense_els_p) begin : g_err_popcount
        $error("bsg_array_expand_serial: popcount(pattern_p) must equal dense_els_p");
    end
    if ((dense_els_p % beat_els_p) != 0) begin : g_err_beats
        $error("bsg_array_expand_serial: dense_els_p must be a multiple of beat_els_p");
    end

    typedef enum logic {
        FILL_S = 1'b0,
        FULL_S = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
    logic [dense_w_lp-1:0]   dense_q, dense_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= FILL_S;
            cnt_q   <= '0;
            dense_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dense_q <= dense_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dense_d = dense_q;
        case (state_q)
            FILL_S: begin
                if (v_i) begin
                    dense_d[cnt_q*beat_w_lp +: beat_w_lp] = data_i;
                    if (cnt_q == cnt_w_lp'(beats_lp - 1)) begin
                        cnt_d   = '0;
                        state_d = FULL_S;
                    end else begin
                        cnt_d = cnt_q + cnt_w_lp'(1);
                    end
                end
            end
            FULL_S: begin
                // Buffer is left as is; the next fill overwrites every slice.
                if (yumi_i) state_d = FILL_S;
            end
            default: state_d = FILL_S;
        endcase
    end

    assign ready_o = (state_q == FILL_S);
    assign v_o     = (state_q == FULL_S);

    // Static scatter: wiring only, unselected positions tied to zero.
    for (genvar j = 0; j < pattern_els_p; j++) begin : g_scatter
        if (pattern_p[j]) begin : g_sel
            localparam int unsigned rank_lp = rank_f(j);
            assign data_o[j*width_p +: width_p] = dense_q[rank_lp*width_p +: width_p];
        end else begin : g_zero
            assign data_o[j*width_p +: width_p] = '0;
        end
    end

endmodule

// File: tb/tb_bsg_array_expand_serial.sv
// Scoreboard bench for bsg_array_expand_serial: a small 8-position configuration
// and the default 512-position configuration, sharing one clock.
module tb_bsg_array_expand_serial;

    localparam logic [7:0] S_PAT = 8'b1011_0010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // small configuration
    logic        s_rst, s_v_i, s_ready_o, s_v_o, s_yumi_i;
    logic [7:0]  s_data_i;
    logic [31:0] s_data_o;

    // default configuration
    logic         d_rst, d_v_i, d_ready_o, d_v_o, d_yumi_i;
    logic [31:0]  d_data_i;
    logic [511:0] d_data_o;

    logic [31:0]  sq[$];
    logic [511:0] dq[$];

    bsg_array_expand_serial #(
        .width_p(4), .pattern_els_p(8), .pattern_p(8'b1011_0010),
        .dense_els_p(4), .beat_els_p(2)
    ) u_small (
        .clk_i(clk), .reset_i(s_rst), .v_i(s_v_i), .data_i(s_data_i),
        .ready_o(s_ready_o), .v_o(s_v_o), .data_o(s_data_o), .yumi_i(s_yumi_i)
    );

    bsg_array_expand_serial u_def (
        .clk_i(clk), .reset_i(d_rst), .v_i(d_v_i), .data_i(d_data_i),
        .ready_o(d_ready_o), .v_o(d_v_o), .data_o(d_data_o), .yumi_i(d_yumi_i)
    );

    always @(posedge clk) begin
        assert (!(s_yumi_i && !s_v_o) && !(d_yumi_i && !d_v_o))
        else begin
            $display("FAIL yumi_protocol yumi asserted while v_o low");
            checks++;
            errors++;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1);
    end

    // Reference scatter for the small configuration.
    function automatic logic [31:0] exp_s(input logic [15:0] dense);
        logic [31:0] r;
        int k;
        r = '0;
        k = 0;
        for (int j = 0; j < 8; j++) begin
            if (S_PAT[j]) begin
                r[j*4 +: 4] = dense[k*4 +: 4];
                k++;
            end
        end
        return r;
    endfunction

    task automatic send_s(input logic [7:0] d);
        int n;
        n = 0;
        s_v_i = 1'b1;
        s_data_i = d;
        while (!s_ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_s_timeout ready_o=%0b required 1", s_ready_o);
        end
        @(posedge clk); #1;
        s_v_i = 1'b0;
    endtask

    task automatic send_d(input logic [31:0] d);
        int n;
        n = 0;
        d_v_i = 1'b1;
        d_data_i = d;
        while (!d_ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_d_timeout ready_o=%0b required 1", d_ready_o);
        end
        @(posedge clk); #1;
        d_v_i = 1'b0;
    endtask

    // Wait for v_o, compare against scoreboard head, then consume with one yumi.
    task automatic obs_s(input string name);
        int n;
        logic [31:0] e;
        n = 0;
        @(negedge clk);
        while (!s_v_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!s_v_o) begin
            errors++;
            $display("FAIL %s_valid_timeout v_o=%0b required 1", name, s_v_o);
        end else if (sq.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected_output data_o=%h required none", name, s_data_o);
        end else begin
            e = sq.pop_front();
            if (s_data_o !== e) begin
                errors++;
                $display("FAIL %s_data data_o=%h required %h", name, s_data_o, e);
            end
            s_yumi_i = 1'b1;
            @(posedge clk); #1;
            s_yumi_i = 1'b0;
            @(negedge clk);
            checks++;
            if (s_v_o !== 1'b0 || s_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL %s_after_yumi v_o=%0b ready_o=%0b required 0 1",
                         name, s_v_o, s_ready_o);
            end
        end
    endtask

    task automatic obs_d(input string name);
        int n;
        logic [511:0] e;
        n = 0;
        @(negedge clk);
        while (!d_v_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!d_v_o) begin
            errors++;
            $display("FAIL %s_valid_timeout v_o=%0b required 1", name, d_v_o);
        end else if (dq.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected_output v_o=1 required none", name);
        end else begin
            e = dq.pop_front();
            if (d_data_o !== e) begin
                errors++;
                $display("FAIL %s_data data_o=%h required %h", name, d_data_o, e);
            end
            d_yumi_i = 1'b1;
            @(posedge clk); #1;
            d_yumi_i = 1'b0;
        end
    endtask

    task automatic test_reset;
        s_rst = 1'b1; d_rst = 1'b1;
        s_v_i = 1'b0; d_v_i = 1'b0;
        s_yumi_i = 1'b0; d_yumi_i = 1'b0;
        s_data_i = '0; d_data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        s_rst = 1'b0; d_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (d_v_o !== 1'b0 || d_ready_o !== 1'b1 || d_data_o !== '0) begin
                errors++;
                $display("FAIL reset_default cycle %0d v_o=%0b ready_o=%0b data_o_nonzero=%0b required 0 1 0",
                         i, d_v_o, d_ready_o, |d_data_o);
            end
            checks++;
            if (s_v_o !== 1'b0 || s_ready_o !== 1'b1 || s_data_o !== 32'h0) begin
                errors++;
                $display("FAIL reset_small cycle %0d v_o=%0b ready_o=%0b data_o=%h required 0 1 0",
                         i, s_v_o, s_ready_o, s_data_o);
            end
        end
    endtask

    // Two beats then hold off the consumer while upstream keeps offering a beat.
    task automatic test_stream_backpressure;
        sq.push_back(32'h4032_0010);
        send_s(8'h21);
        send_s(8'h43);
        @(negedge clk);
        checks++;
        if (s_v_o !== 1'b1 || s_ready_o !== 1'b0 || s_data_o !== 32'h4032_0010) begin
            errors++;
            $display("FAIL stream_latency v_o=%0b ready_o=%0b data_o=%h required 1 0 40320010",
                     s_v_o, s_ready_o, s_data_o);
        end
        s_v_i = 1'b1;
        s_data_i = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (s_v_o !== 1'b1 || s_ready_o !== 1'b0 || s_data_o !== 32'h4032_0010) begin
                errors++;
                $display("FAIL backpressure_hold cycle %0d v_o=%0b ready_o=%0b data_o=%h required 1 0 40320010",
                         i, s_v_o, s_ready_o, s_data_o);
            end
        end
        // yumi with v_i still high: the FF beat must land only after the bubble cycle
        s_yumi_i = 1'b1;
        @(posedge clk); #1;
        s_yumi_i = 1'b0;
        sq.pop_front();
        checks++;
        if (s_v_o !== 1'b0 || s_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL yumi_release v_o=%0b ready_o=%0b required 0 1", s_v_o, s_ready_o);
        end
        @(posedge clk); #1;
        checks++;
        if (s_v_o !== 1'b0) begin
            errors++;
            $display("FAIL bubble_first_beat v_o=%0b required 0", s_v_o);
        end
        @(posedge clk); #1;
        s_v_i = 1'b0;
        checks++;
        if (s_v_o !== 1'b1 || s_data_o !== 32'hF0FF_00F0) begin
            errors++;
            $display("FAIL post_yumi_accept v_o=%0b data_o=%h required 1 f0ff00f0", s_v_o, s_data_o);
        end
        sq.push_back(32'hF0FF_00F0);
        obs_s("post_yumi_drain");
    endtask

    task automatic test_default_full;
        logic [255:0] dense;
        dq.push_back({256'h0, {8{32'hAAAA_AAAA}}});
        for (int b = 0; b < 8; b++) begin
            logic [31:0] beat;
            for (int e = 0; e < 32; e++) beat[e] = 1'((b*32 + e) % 2);
            send_d(beat);
        end
        obs_d("default_pattern");
        for (int b = 0; b < 8; b++) dense[b*32 +: 32] = $urandom;
        dq.push_back({256'h0, dense});
        for (int b = 0; b < 8; b++) send_d(dense[b*32 +: 32]);
        obs_d("default_random");
    endtask

    task automatic test_back_to_back;
        logic [15:0] dense;
        for (int i = 0; i < 6; i++) begin
            dense = 16'($urandom);
            sq.push_back(exp_s(dense));
            send_s(dense[7:0]);
            send_s(dense[15:8]);
            obs_s("back_to_back");
        end
    endtask

    task automatic test_reset_midfill;
        send_s(8'h21);
        s_rst = 1'b1;
        @(posedge clk); #1;
        s_rst = 1'b0;
        sq.push_back(32'h8076_0050);
        send_s(8'h65);
        send_s(8'h87);
        obs_s("reset_midfill");
    endtask

    task automatic test_reset_full;
        send_s(8'h21);
        send_s(8'h43);
        @(negedge clk);
        checks++;
        if (s_v_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_full_pre v_o=%0b required 1", s_v_o);
        end
        #2;
        s_rst = 1'b1;
        #1;
        checks++;
        if (s_v_o !== 1'b0 || s_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_full_async v_o=%0b data_o=%h required 0 0", s_v_o, s_data_o);
        end
        @(posedge clk); #1;
        s_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready_o !== 1'b1 || s_v_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_full_after ready_o=%0b v_o=%0b required 1 0", s_ready_o, s_v_o);
        end
    endtask

    initial begin
        test_reset();
        test_stream_backpressure();
        test_default_full();
        test_back_to_back();
        test_reset_midfill();
        test_reset_full();
        checks++;
        if (sq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover small=%0d default=%0d required 0 0", sq.size(), dq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
